psum_wb: RTL and testbench

Write-back stage directly downstream of the SFU accumulator. It captures each accumulated partial sum from the SFU output, buffers it in a small FIFO, optionally applies ReLU, and writes it to the psum SRAM at sequential addresses from a programmed base. A 1-cycle `done` pulse marks the end of the tile so the controller can start the next accumulation pass.

---
 rtl/psum_wb.sv | 145 ++++++++++++++
 tb/tb_psum_wb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_wb.sv
// Partial-sum write-back: buffers SFU results in a small FIFO, optionally applies
// ReLU, and streams them to the psum SRAM at sequential addresses from a base.
module psum_wb #(
  parameter int unsigned psum_bw    = 32,
  parameter int unsigned addr_bw    = 11,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [addr_bw-1:0]        base_addr,
  input  logic [addr_bw-1:0]        num_words,
  input  logic                      relu_en,
  input  logic                      in_valid,
  input  logic signed [psum_bw-1:0] psum_in,
  input  logic                      mem_busy,
  output logic                      in_ready,
  output logic                      mem_wr_en,
  output logic [addr_bw-1:0]        mem_addr,
  output logic [psum_bw-1:0]        mem_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam int unsigned ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned cnt_w = ptr_w + 1;

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_run  = 1'b1;

  logic [0:0]         state, state_nxt;
  logic [psum_bw-1:0] fifo_mem [fifo_depth];
  logic [ptr_w-1:0]   rd_ptr, wr_ptr;
  logic [cnt_w-1:0]   count;
  logic [addr_bw-1:0] base_q, nw_q, wr_cnt;
  logic               relu_q;
  logic [psum_bw-1:0] head;
  logic               full, empty;
  logic               start_ok, push, pop, drop, last, done_nxt;

  assign full     = (count == cnt_w'(fifo_depth));
  assign empty    = (count == '0);
  assign in_ready = ~full;
  assign busy     = (state == st_run);
  assign head     = fifo_mem[rd_ptr];

  // Next-state and per-cycle control decode
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    drop      = 1'b0;
    last      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      st_idle: begin
        if (start) begin
          start_ok = 1'b1;
          if (num_words != '0) state_nxt = st_run;
          else                 done_nxt  = 1'b1;
        end
      end
      st_run: begin
        pop  = ~empty & ~mem_busy;
        last = pop & (wr_cnt == nw_q - addr_bw'(1));
        // A full FIFO still accepts a word when the head leaves on the same edge
        if (in_valid) begin
          if (~full | pop) push = 1'b1;
          else             drop = 1'b1;
        end
        if (last) begin
          state_nxt = st_idle;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= st_idle;
    else          state <= state_nxt;
  end

  // FIFO storage carries no reset; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= psum_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_ok) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_w'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
      count <= count + cnt_w'(push) - cnt_w'(pop);
    end
  end

  // Tile configuration, write counter and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      nw_q     <= '0;
      relu_q   <= 1'b0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else if (start_ok) begin
      base_q   <= base_addr;
      nw_q     <= num_words;
      relu_q   <= relu_en;
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)  wr_cnt   <= wr_cnt + addr_bw'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // SRAM write port; address and data hold between writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      done      <= 1'b0;
    end else begin
      mem_wr_en <= pop;
      done      <= done_nxt;
      if (pop) begin
        mem_addr <= base_q + wr_cnt;
        mem_data <= (relu_q && head[psum_bw-1]) ? '0 : head;
      end
    end
  end

endmodule

// File: tb/tb_psum_wb.sv
// Directed bench for psum_wb: inputs driven and outputs sampled on the falling edge.
module tb_psum_wb;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [10:0]        base_addr;
  logic [10:0]        num_words;
  logic               relu_en;
  logic               in_valid;
  logic signed [31:0] psum_in;
  logic               mem_busy;
  logic               in_ready;
  logic               mem_wr_en;
  logic [10:0]        mem_addr;
  logic [31:0]        mem_data;
  logic               busy;
  logic               done;
  logic               overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psum_wb #(.psum_bw(32), .addr_bw(11), .fifo_depth(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .relu_en(relu_en), .in_valid(in_valid),
    .psum_in(psum_in), .mem_busy(mem_busy), .in_ready(in_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .overflow(overflow)
  );

  // Pulse start for one cycle; returns at the first falling edge after acceptance
  task automatic begin_tile(input logic [10:0] b, input logic [10:0] n, input logic r);
    start = 1'b1; base_addr = b; num_words = n; relu_en = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; relu_en = 1'b0;
    in_valid = 1'b0; psum_in = '0; mem_busy = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if (mem_addr !== 11'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", mem_addr); end
    checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", mem_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] vals [4];
    vals = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'd0};
    begin_tile(11'h010, 11'd4, 1'b0);
    for (int c = 0; c < 8; c++) begin
      checks++; if (busy !== (c < 5)) begin errors++; $display("FAIL basic_busy c=%0d: got %b expected %b", c, busy, (c < 5)); end
      checks++; if (mem_wr_en !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL basic_wr_en c=%0d: got %b", c, mem_wr_en); end
      checks++; if (done !== (c == 5)) begin errors++; $display("FAIL basic_done c=%0d: got %b expected %b", c, done, (c == 5)); end
      if (c >= 2 && c <= 5) begin
        checks++; if (mem_addr !== 11'(11'h010 + c - 2)) begin errors++; $display("FAIL basic_addr c=%0d: got %h expected %h", c, mem_addr, 11'(11'h010 + c - 2)); end
        checks++; if (mem_data !== vals[c-2]) begin errors++; $display("FAIL basic_data c=%0d: got %h expected %h", c, mem_data, vals[c-2]); end
      end
      in_valid = (c < 4);
      if (c < 4) psum_in = vals[c];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_relu();
    logic [31:0] vals [6];
    logic [31:0] expv [6];
    vals = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF};
    expv = '{32'd5, 32'd0, 32'd7, 32'd0, 32'd0, 32'h7FFF_FFFF};
    begin_tile(11'h020, 11'd6, 1'b1);
    for (int c = 0; c < 9; c++) begin
      checks++; if (mem_wr_en !== (c >= 2 && c <= 7)) begin errors++; $display("FAIL relu_wr_en c=%0d: got %b", c, mem_wr_en); end
      checks++; if (done !== (c == 7)) begin errors++; $display("FAIL relu_done c=%0d: got %b expected %b", c, done, (c == 7)); end
      if (c >= 2 && c <= 7) begin
        checks++; if (mem_data !== expv[c-2]) begin errors++; $display("FAIL relu_data c=%0d: got %h expected %h", c, mem_data, expv[c-2]); end
        checks++; if (mem_addr !== 11'(11'h020 + c - 2)) begin errors++; $display("FAIL relu_addr c=%0d: got %h", c, mem_addr); end
      end
      in_valid = (c < 6);
      if (c < 6) psum_in = vals[c];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [5];
    vals = '{32'h11, 32'hFFFF_FF00, 32'h33, 32'h44, 32'h55};
    // Stall for 6 cycles while 4 words arrive
    begin_tile(11'h100, 11'd4, 1'b0);
    for (int c = 0; c < 12; c++) begin
      checks++; if (mem_wr_en !== (c >= 7 && c <= 10)) begin errors++; $display("FAIL bp_wr_en c=%0d: got %b", c, mem_wr_en); end
      checks++; if (in_ready !== !(c >= 4 && c <= 6)) begin errors++; $display("FAIL bp_in_ready c=%0d: got %b", c, in_ready); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow c=%0d: got %b expected 0", c, overflow); end
      checks++; if (done !== (c == 10)) begin errors++; $display("FAIL bp_done c=%0d: got %b", c, done); end
      if (c >= 7 && c <= 10) begin
        checks++; if (mem_data !== vals[c-7]) begin errors++; $display("FAIL bp_data c=%0d: got %h expected %h", c, mem_data, vals[c-7]); end
        checks++; if (mem_addr !== 11'(11'h100 + c - 7)) begin errors++; $display("FAIL bp_addr c=%0d: got %h", c, mem_addr); end
      end
      mem_busy = (c < 6);
      in_valid = (c < 4);
      if (c < 4) psum_in = vals[c];
      @(negedge clk);
    end
    // Fifth push against a full, stalled FIFO is dropped
    begin_tile(11'h200, 11'd4, 1'b0);
    for (int c = 0; c < 11; c++) begin
      checks++; if (overflow !== (c >= 5)) begin errors++; $display("FAIL ovf_flag c=%0d: got %b expected %b", c, overflow, (c >= 5)); end
      checks++; if (in_ready !== !(c == 4 || c == 5)) begin errors++; $display("FAIL ovf_in_ready c=%0d: got %b", c, in_ready); end
      checks++; if (mem_wr_en !== (c >= 6 && c <= 9)) begin errors++; $display("FAIL ovf_wr_en c=%0d: got %b", c, mem_wr_en); end
      checks++; if (done !== (c == 9)) begin errors++; $display("FAIL ovf_done c=%0d: got %b", c, done); end
      if (c >= 6 && c <= 9) begin
        checks++; if (mem_data !== vals[c-6]) begin errors++; $display("FAIL ovf_data c=%0d: got %h expected %h", c, mem_data, vals[c-6]); end
      end
      mem_busy = (c < 5);
      in_valid = (c < 5);
      if (c < 5) psum_in = vals[c];
      @(negedge clk);
    end
    mem_busy = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [10:0] a;
    begin_tile(11'h7FE, 11'd3, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL start_clears_overflow: got %b expected 0", overflow); end
    for (int c = 0; c < 6; c++) begin
      a = 11'h7FE + 11'(c - 2);
      checks++; if (mem_wr_en !== (c >= 2 && c <= 4)) begin errors++; $display("FAIL wrap_wr_en c=%0d: got %b", c, mem_wr_en); end
      checks++; if (done !== (c == 4)) begin errors++; $display("FAIL wrap_done c=%0d: got %b", c, done); end
      if (c >= 2 && c <= 4) begin
        checks++; if (mem_addr !== a) begin errors++; $display("FAIL wrap_addr c=%0d: got %h expected %h", c, mem_addr, a); end
        checks++; if (mem_data !== 32'(9 + c - 2)) begin errors++; $display("FAIL wrap_data c=%0d: got %h", c, mem_data); end
      end
      in_valid = (c < 3);
      psum_in = 32'(9 + c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    // Empty tile: done one cycle after start, no write, write port holds
    begin_tile(11'h123, 11'd0, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL zero_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if (mem_addr !== 11'h000) begin errors++; $display("FAIL zero_addr_hold: got %h expected 000", mem_addr); end
    checks++; if (mem_data !== 32'd11) begin errors++; $display("FAIL zero_data_hold: got %h expected b", mem_data); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b expected 0", done); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL zero_wr_en2: got %b expected 0", mem_wr_en); end
  endtask

  task automatic test_reset_mid();
    begin_tile(11'h300, 11'd4, 1'b0);
    for (int c = 0; c < 4; c++) begin
      checks++; if (mem_wr_en !== (c >= 2)) begin errors++; $display("FAIL mid_wr_en c=%0d: got %b", c, mem_wr_en); end
      if (c >= 2) begin
        checks++; if (mem_addr !== 11'(11'h300 + c - 2)) begin errors++; $display("FAIL mid_addr c=%0d: got %h", c, mem_addr); end
      end
      if (c < 3) begin
        in_valid = 1'b1;
        psum_in = 32'(c + 100);
        @(negedge clk);
      end
    end
    // Reset between clock edges must act immediately
    #2 reset_n = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL async_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if (mem_addr !== 11'h000) begin errors++; $display("FAIL async_addr: got %h expected 000", mem_addr); end
    checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL async_data: got %h expected 0", mem_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready: got %b expected 1", in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL async_overflow: got %b expected 0", overflow); end
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL async_no_done: got %b expected 0", done); end
    reset_n = 1'b1;
    @(negedge clk);
    begin_tile(11'h050, 11'd2, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checks++; if (mem_wr_en !== (c == 2 || c == 3)) begin errors++; $display("FAIL post_wr_en c=%0d: got %b", c, mem_wr_en); end
      checks++; if (done !== (c == 3)) begin errors++; $display("FAIL post_done c=%0d: got %b", c, done); end
      if (c == 2 || c == 3) begin
        checks++; if (mem_addr !== 11'(11'h050 + c - 2)) begin errors++; $display("FAIL post_addr c=%0d: got %h", c, mem_addr); end
        checks++; if (mem_data !== 32'(32'hAA + 17 * (c - 2))) begin errors++; $display("FAIL post_data c=%0d: got %h", c, mem_data); end
      end
      in_valid = (c < 2);
      psum_in = 32'(32'hAA + 17 * c);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ignored();
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      psum_in = 32'd99;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || mem_wr_en !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL idle_push c=%0d: busy=%b wr_en=%b in_ready=%b expected 0 0 1", c, busy, mem_wr_en, in_ready); end
    end
    in_valid = 1'b0;
    begin_tile(11'h400, 11'd2, 1'b0);
    for (int c = 0; c < 7; c++) begin
      checks++; if (busy !== (c < 3)) begin errors++; $display("FAIL ign_busy c=%0d: got %b", c, busy); end
      checks++; if (mem_wr_en !== (c == 2 || c == 3)) begin errors++; $display("FAIL ign_wr_en c=%0d: got %b", c, mem_wr_en); end
      checks++; if (done !== (c == 3)) begin errors++; $display("FAIL ign_done c=%0d: got %b", c, done); end
      if (c == 2 || c == 3) begin
        checks++; if (mem_addr !== 11'(11'h400 + c - 2)) begin errors++; $display("FAIL ign_addr c=%0d: got %h", c, mem_addr); end
        checks++; if (mem_data !== 32'(11 * (c - 1))) begin errors++; $display("FAIL ign_data c=%0d: got %h", c, mem_data); end
      end
      in_valid = (c < 2);
      psum_in = 32'(11 * (c + 1));
      start = (c == 1);
      if (c == 1) begin base_addr = 11'h600; num_words = 11'd5; end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
